// File: rtl/ip_ctrl_pkg.sv
// Shared constants for the IP access controller: opcodes, FSM encoding and
// error status bit positions.
package ip_ctrl_pkg;

  localparam logic [5:0] OP_LWIP = 6'b111111;
  localparam logic [5:0] OP_SWIP = 6'b111110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam int unsigned ERR_SEL_BIT = 0;
  localparam int unsigned ERR_TO_BIT  = 1;

endpackage

// File: rtl/ip_timeout_cnt.sv
// Cycle counter for the BUSY phase; expired is high on the last allowed
// cycle before a timeout is declared.
module ip_timeout_cnt #(
  parameter int unsigned TO_W    = 8,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/ip_access_ctrl.sv
// Sequences LWIP/SWIP instructions onto one of NUM_IP peripherals through a
// level req / ack handshake, stalling the pipeline until ack or timeout.
module ip_access_ctrl
  import ip_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IP  = 4,
  parameter int unsigned DW      = 32,
  parameter int unsigned TO_W    = 8,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_vld,
  input  logic [5:0]           opcode,
  input  logic [4:0]           ip_sel,
  input  logic [DW-1:0]        cpu_wdata,
  input  logic                 err_clr,
  output logic                 stall,
  output logic [NUM_IP-1:0]    ip_req,
  output logic                 ip_we,
  output logic [DW-1:0]        ip_wdata,
  input  logic [NUM_IP-1:0]    ip_ack,
  input  logic [NUM_IP*DW-1:0] ip_rdata,
  output logic [DW-1:0]        cpu_rdata,
  output logic                 rd_vld,
  output logic                 err_pulse,
  output logic [1:0]           err_sts
);

  localparam int unsigned SW = (NUM_IP > 1) ? $clog2(NUM_IP) : 1;
  localparam int unsigned RW = $clog2(NUM_IP * DW);

  state_t        state, state_nx;
  logic [SW-1:0] sel_q, sel_nx;
  logic          we_q, we_nx;
  logic          ip_op, bad_sel, ack_sel, expired;
  logic [1:0]    set_bits;
  logic [RW-1:0] rbase;

  assign ip_op   = issue_vld & ((opcode == OP_LWIP) | (opcode == OP_SWIP));
  assign bad_sel = (32'(ip_sel) >= NUM_IP);
  assign ack_sel = ip_ack[sel_q];
  assign rbase   = RW'(sel_q) * RW'(DW);

  ip_timeout_cnt #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != ST_BUSY),
    .enable  (state == ST_BUSY),
    .expired (expired)
  );

  always_comb begin
    state_nx  = state;
    sel_nx    = sel_q;
    we_nx     = we_q;
    stall     = 1'b0;
    rd_vld    = 1'b0;
    err_pulse = 1'b0;
    set_bits  = '0;
    case (state)
      ST_IDLE: begin
        if (ip_op) begin
          stall = 1'b1;
          if (bad_sel) begin
            state_nx              = ST_ERR;
            set_bits[ERR_SEL_BIT] = 1'b1;
          end else begin
            state_nx = ST_BUSY;
            sel_nx   = ip_sel[SW-1:0];
            we_nx    = (opcode == OP_SWIP);
          end
        end
      end
      ST_BUSY: begin
        stall = 1'b1;
        if (ack_sel) begin
          state_nx = ST_DONE;
        end else if (expired) begin
          state_nx             = ST_ERR;
          set_bits[ERR_TO_BIT] = 1'b1;
        end
      end
      ST_DONE: begin
        rd_vld   = ~we_q;
        state_nx = ST_IDLE;
      end
      ST_ERR: begin
        err_pulse = 1'b1;
        state_nx  = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Request strobes are decoded from next-state so they are registered yet
  // line up exactly with the BUSY cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      sel_q     <= '0;
      we_q      <= 1'b0;
      ip_req    <= '0;
      ip_we     <= 1'b0;
      ip_wdata  <= '0;
      cpu_rdata <= '0;
      err_sts   <= '0;
    end else begin
      state  <= state_nx;
      sel_q  <= sel_nx;
      we_q   <= we_nx;
      ip_req <= (state_nx == ST_BUSY) ? (NUM_IP'(1) << sel_nx) : '0;
      ip_we  <= (state_nx == ST_BUSY) & we_nx;
      if (state == ST_IDLE && state_nx == ST_BUSY) begin
        ip_wdata <= cpu_wdata;
      end
      if (state == ST_BUSY && ack_sel && !we_q) begin
        cpu_rdata <= ip_rdata[rbase +: DW];
      end
      err_sts <= (err_clr ? 2'b00 : err_sts) | set_bits;
    end
  end

endmodule

// File: tb/tb_ip_access_ctrl.sv
// Directed bench for ip_access_ctrl with hand-computed expectations.
module tb_ip_access_ctrl;

  localparam int unsigned NUM_IP  = 4;
  localparam int unsigned DW      = 32;
  localparam int unsigned TO_W    = 8;
  localparam int unsigned TIMEOUT = 10;

  localparam logic [5:0] LWIP = 6'b111111;
  localparam logic [5:0] SWIP = 6'b111110;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 issue_vld;
  logic [5:0]           opcode;
  logic [4:0]           ip_sel;
  logic [DW-1:0]        cpu_wdata;
  logic                 err_clr;
  logic                 stall;
  logic [NUM_IP-1:0]    ip_req;
  logic                 ip_we;
  logic [DW-1:0]        ip_wdata;
  logic [NUM_IP-1:0]    ip_ack;
  logic [NUM_IP*DW-1:0] ip_rdata;
  logic [DW-1:0]        cpu_rdata;
  logic                 rd_vld;
  logic                 err_pulse;
  logic [1:0]           err_sts;

  int tests = 0;
  int fails = 0;

  ip_access_ctrl #(
    .NUM_IP  (NUM_IP),
    .DW      (DW),
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .issue_vld (issue_vld),
    .opcode    (opcode),
    .ip_sel    (ip_sel),
    .cpu_wdata (cpu_wdata),
    .err_clr   (err_clr),
    .stall     (stall),
    .ip_req    (ip_req),
    .ip_we     (ip_we),
    .ip_wdata  (ip_wdata),
    .ip_ack    (ip_ack),
    .ip_rdata  (ip_rdata),
    .cpu_rdata (cpu_rdata),
    .rd_vld    (rd_vld),
    .err_pulse (err_pulse),
    .err_sts   (err_sts)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [5:0] op, input logic [4:0] sel, input logic [DW-1:0] wd);
    issue_vld = 1'b1;
    opcode    = op;
    ip_sel    = sel;
    cpu_wdata = wd;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    issue_vld = 1'b0;
    opcode    = '0;
    ip_sel    = '0;
    cpu_wdata = '0;
    err_clr   = 1'b0;
    ip_ack    = '0;
    ip_rdata  = {32'hAAAA5555, 32'hCAFEF00D, 32'h0BADF00D, 32'h12345678};
    tick();
    tick();
    chk("rst_stall", stall, 0);
    chk("rst_req", ip_req, 0);
    chk("rst_we", ip_we, 0);
    chk("rst_wdata", ip_wdata, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_rdvld", rd_vld, 0);
    chk("rst_errp", err_pulse, 0);
    chk("rst_errsts", err_sts, 0);
    rst = 1'b0;
    tick();

    // 1: SWIP to IP2, ack in third req cycle
    issue(SWIP, 5'd2, 32'hDEADBEEF);
    chk("t1_stall_T", stall, 1);
    chk("t1_req_T", ip_req, 0);
    tick();
    issue_vld = 1'b0; #1;
    chk("t1_req_1", ip_req, 4'b0100);
    chk("t1_we", ip_we, 1);
    chk("t1_wdata", ip_wdata, 32'hDEADBEEF);
    chk("t1_stall_1", stall, 1);
    tick();
    chk("t1_req_2", ip_req, 4'b0100);
    chk("t1_stall_2", stall, 1);
    tick();
    ip_ack = 4'b0100; #1;
    chk("t1_req_3", ip_req, 4'b0100);
    chk("t1_stall_3", stall, 1);
    tick();
    ip_ack = '0; #1;
    chk("t1_done_stall", stall, 0);
    chk("t1_done_req", ip_req, 0);
    chk("t1_done_rdvld", rd_vld, 0);
    chk("t1_done_we", ip_we, 0);
    tick();

    // 2: LWIP from IP0, ack on first req cycle
    issue(LWIP, 5'd0, 32'h0);
    tick();
    issue_vld = 1'b0;
    ip_ack    = 4'b0001; #1;
    chk("t2_req", ip_req, 4'b0001);
    chk("t2_we", ip_we, 0);
    tick();
    ip_ack = '0; #1;
    chk("t2_rdvld", rd_vld, 1);
    chk("t2_rdata", cpu_rdata, 32'h12345678);
    chk("t2_stall", stall, 0);
    tick();
    chk("t2_rdvld_off", rd_vld, 0);
    chk("t2_rdata_hold", cpu_rdata, 32'h12345678);

    // 3: LWIP with out-of-range select
    issue(LWIP, 5'd5, 32'h0);
    chk("t3_stall_T", stall, 1);
    tick();
    issue_vld = 1'b0; #1;
    chk("t3_errp", err_pulse, 1);
    chk("t3_req", ip_req, 0);
    chk("t3_stall", stall, 0);
    chk("t3_rdvld", rd_vld, 0);
    tick();
    chk("t3_errsts", err_sts, 2'b01);
    chk("t3_errp_off", err_pulse, 0);
    chk("t3_rdata", cpu_rdata, 32'h12345678);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0; #1;
    chk("t3_clr", err_sts, 2'b00);

    // 4: SWIP to IP1 never acked, unrelated IP3 ack toggles
    issue(SWIP, 5'd1, 32'h55AA55AA);
    tick();
    issue_vld = 1'b0;
    for (int i = 0; i < int'(TIMEOUT); i++) begin
      ip_ack = (i % 2 == 1) ? 4'b1000 : 4'b0000; #1;
      chk("t4_req", ip_req, 4'b0010);
      chk("t4_stall", stall, 1);
      tick();
    end
    ip_ack = '0; #1;
    chk("t4_errp", err_pulse, 1);
    chk("t4_stall_err", stall, 0);
    chk("t4_req_err", ip_req, 0);
    tick();
    chk("t4_errsts", err_sts, 2'b10);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0; #1;
    chk("t4_clr", err_sts, 2'b00);

    // 5: LWIP from IP3 acked on exactly the timeout cycle
    issue(LWIP, 5'd3, 32'h0);
    tick();
    issue_vld = 1'b0;
    for (int i = 0; i < int'(TIMEOUT) - 1; i++) begin
      tick();
    end
    ip_ack = 4'b1000; #1;
    chk("t5_req_last", ip_req, 4'b1000);
    tick();
    ip_ack = '0; #1;
    chk("t5_rdvld", rd_vld, 1);
    chk("t5_errp", err_pulse, 0);
    chk("t5_rdata", cpu_rdata, 32'hAAAA5555);
    tick();
    chk("t5_errsts", err_sts, 2'b00);

    // 6: reset in the middle of BUSY, then back-to-back LWIPs
    issue(LWIP, 5'd7, 32'h0);
    tick();
    issue_vld = 1'b0; #1;
    tick();
    chk("t6_pre_errsts", err_sts, 2'b01);
    issue(SWIP, 5'd1, 32'h11112222);
    tick();
    issue_vld = 1'b0; #1;
    chk("t6_busy_req", ip_req, 4'b0010);
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    chk("t6_req", ip_req, 0);
    chk("t6_stall", stall, 0);
    chk("t6_errsts", err_sts, 2'b00);
    chk("t6_rdvld", rd_vld, 0);
    chk("t6_errp", err_pulse, 0);
    chk("t6_rdata", cpu_rdata, 0);
    issue(LWIP, 5'd1, 32'h0);
    tick();
    issue_vld = 1'b0;
    ip_ack    = 4'b0010; #1;
    tick();
    ip_ack = '0; #1;
    chk("t6_a_rdvld", rd_vld, 1);
    chk("t6_a_rdata", cpu_rdata, 32'h0BADF00D);
    tick();
    issue(LWIP, 5'd2, 32'h0);
    tick();
    issue_vld = 1'b0;
    ip_ack    = 4'b0100; #1;
    chk("t6_b_req", ip_req, 4'b0100);
    tick();
    ip_ack = '0; #1;
    chk("t6_b_rdvld", rd_vld, 1);
    chk("t6_b_rdata", cpu_rdata, 32'hCAFEF00D);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
